// File: rtl/instruction_fetch_decode_pkg.sv
// Shared definitions for the fetch/decode front end: FSM encoding, opcode
// constants and instruction field positions.
package instruction_fetch_decode_pkg;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_ISSUE = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   localparam logic [1:0] OPC_ALU  = 2'b00;
   localparam logic [1:0] OPC_ADDI = 2'b01;
   localparam logic [1:0] OPC_MEM  = 2'b10;
   localparam logic [1:0] OPC_BR   = 2'b11;

   localparam int OPC_MSB = 7;
   localparam int RD_MSB  = 5;
   localparam int RS_MSB  = 2;

   localparam logic [7:0] HALT_INSTR_DEFAULT = 8'hFF;

endpackage

// File: rtl/instruction_fetch_decode_instr_field_decoder.sv
// Combinational slicer from an 8-bit instruction word to its decoded fields.
// rs and imm3 share the low bits; the consumer decides which form applies.
module instr_field_decoder
   import instruction_fetch_decode_pkg::*;
(
   input  logic [7:0] ir_i,
   output logic [1:0] opcode_o,
   output logic [2:0] rd_o,
   output logic [2:0] rs_o,
   output logic [2:0] imm3_o
);

   assign opcode_o = ir_i[OPC_MSB -: 2];
   assign rd_o     = ir_i[RD_MSB -: 3];
   assign rs_o     = ir_i[RS_MSB -: 3];
   assign imm3_o   = ir_i[RS_MSB -: 3];

endmodule

// File: rtl/instruction_fetch_decode.sv
// Fetch/decode front end: PC, request/valid handshake to instruction memory,
// instruction register and decoded fields. One instruction in flight at a time.
module instruction_fetch_decode
   import instruction_fetch_decode_pkg::*;
#(
   parameter int                ADDR_W     = 8,
   parameter logic [ADDR_W-1:0] PC_RESET   = '0,
   parameter logic [7:0]        HALT_INSTR = HALT_INSTR_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [7:0]        imem_rdata,
   input  logic              imem_valid,
   output logic              instr_valid,
   input  logic              instr_ack,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_value,
   output logic [1:0]        opcode,
   output logic [2:0]        rd,
   output logic [2:0]        rs,
   output logic [2:0]        imm3,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;
   logic [7:0]        ir_q, ir_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_REQ;
         pc_q     <= PC_RESET;
         pc_out_q <= PC_RESET;
         ir_q     <= 8'h00;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc_out_q <= pc_out_d;
         ir_q     <= ir_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pc_out_d = pc_out_q;
      ir_d     = ir_q;
      // A redirect outranks everything and flushes a same-cycle memory response.
      if (pc_load) begin
         pc_d    = pc_load_value;
         state_d = S_REQ;
      end else begin
         case (state_q)
            S_REQ: begin
               if (imem_valid) begin
                  ir_d     = imem_rdata;
                  pc_out_d = pc_q;
                  pc_d     = pc_q + 1'b1;
                  state_d  = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (instr_ack) begin
                  state_d = (ir_q == HALT_INSTR) ? S_HALT : S_REQ;
               end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_REQ;
         endcase
      end
   end

   assign imem_req    = (state_q == S_REQ);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == S_ISSUE);
   assign halted      = (state_q == S_HALT);
   assign pc_out      = pc_out_q;

   instr_field_decoder u_dec (
      .ir_i     (ir_q),
      .opcode_o (opcode),
      .rd_o     (rd),
      .rs_o     (rs),
      .imm3_o   (imm3)
   );

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// Bench for instruction_fetch_decode: vector table of fetches with a
// scoreboard popped by an instr_valid monitor, plus redirect/halt/reset cases.
module tb_instruction_fetch_decode;

   logic       clk = 1'b0;
   logic       reset;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic [7:0] imem_rdata;
   logic       imem_valid;
   logic       instr_valid;
   logic       instr_ack;
   logic       pc_load;
   logic [7:0] pc_load_value;
   logic [1:0] opcode;
   logic [2:0] rd, rs, imm3;
   logic [7:0] pc_out;
   logic       halted;

   instruction_fetch_decode dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_valid    (imem_valid),
      .instr_valid   (instr_valid),
      .instr_ack     (instr_ack),
      .pc_load       (pc_load),
      .pc_load_value (pc_load_value),
      .opcode        (opcode),
      .rd            (rd),
      .rs            (rs),
      .imm3          (imm3),
      .pc_out        (pc_out),
      .halted        (halted)
   );

   // Disassembly helper for the transaction log only.
   logic [7:0] mon_ir = 8'h00;
   logic [1:0] dis_opc;
   logic [2:0] dis_rd, dis_rs, dis_imm;
   instr_field_decoder u_dis (
      .ir_i     (mon_ir),
      .opcode_o (dis_opc),
      .rd_o     (dis_rd),
      .rs_o     (dis_rs),
      .imm3_o   (dis_imm)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         wait_cyc;
      int         hold_cyc;
      logic [1:0] opc;
      logic [2:0] rd;
      logic [2:0] rs;
   } vec_t;

   typedef struct {
      logic [7:0] addr;
      logic [1:0] opc;
      logic [2:0] rd;
      logic [2:0] rs;
   } exp_t;

   exp_t       sb[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_pc;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer: every rising instr_valid must match a pushed fetch.
   logic prev_v = 1'b0;
   always @(negedge clk) begin
      if (instr_valid && !prev_v) begin
         if (sb.size() == 0) begin
            chk("unexpected_instr_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_opcode", opcode, e.opc);
            chk("sb_rd", rd, e.rd);
            chk("sb_rs", rs, e.rs);
            chk("sb_imm3", imm3, e.rs);
            chk("sb_pc_out", pc_out, e.addr);
            $display("[TB] issue pc=%02h ir=%02h op=%0d rd=r%0d rs=r%0d imm=%0d",
                     pc_out, mon_ir, dis_opc, dis_rd, dis_rs, dis_imm);
         end
      end
      prev_v = instr_valid;
   end

   task automatic fetch(input vec_t v);
      chk("req_before", imem_req, 1);
      chk("addr_before", imem_addr, exp_pc);
      for (int w = 0; w < v.wait_cyc; w++) begin
         step();
         chk("wait_req", imem_req, 1);
         chk("wait_addr", imem_addr, exp_pc);
         chk("wait_valid", instr_valid, 0);
      end
      imem_rdata = v.data;
      imem_valid = 1'b1;
      mon_ir     = v.data;
      sb.push_back('{addr: exp_pc, opc: v.opc, rd: v.rd, rs: v.rs});
      step();
      imem_valid = 1'b0;
      chk("valid_latency", instr_valid, 1);
      chk("issue_req", imem_req, 0);
      for (int h = 0; h < v.hold_cyc; h++) begin
         imem_valid = 1'b1;
         imem_rdata = ~v.data;
         step();
         imem_valid = 1'b0;
         chk("hold_valid", instr_valid, 1);
         chk("hold_opcode", opcode, v.opc);
         chk("hold_rd", rd, v.rd);
         chk("hold_rs", rs, v.rs);
         chk("hold_pc_out", pc_out, exp_pc);
      end
      instr_ack = 1'b1;
      step();
      instr_ack = 1'b0;
      exp_pc = exp_pc + 8'd1;
      chk("ack_drop_valid", instr_valid, 0);
      if (v.data == 8'hFF) begin
         chk("halt_flag", halted, 1);
         chk("halt_req", imem_req, 0);
      end else begin
         chk("next_req", imem_req, 1);
         chk("next_addr", imem_addr, exp_pc);
         chk("next_halted", halted, 0);
      end
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{data: 8'h5A, wait_cyc: 0, hold_cyc: 0, opc: 2'b01, rd: 3'b011, rs: 3'b010};
      vecs[1] = '{data: 8'hC7, wait_cyc: 3, hold_cyc: 0, opc: 2'b11, rd: 3'b000, rs: 3'b111};
      vecs[2] = '{data: 8'h3D, wait_cyc: 1, hold_cyc: 2, opc: 2'b00, rd: 3'b111, rs: 3'b101};
      vecs[3] = '{data: 8'h81, wait_cyc: 2, hold_cyc: 0, opc: 2'b10, rd: 3'b000, rs: 3'b001};
      vecs[4] = '{data: 8'h00, wait_cyc: 0, hold_cyc: 1, opc: 2'b00, rd: 3'b000, rs: 3'b000};

      reset = 1'b1; imem_rdata = 8'h00; imem_valid = 1'b0; instr_ack = 1'b0;
      pc_load = 1'b0; pc_load_value = 8'h00;
      step();
      step();
      chk("rst_valid", instr_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_addr", imem_addr, 8'h00);
      chk("rst_pc_out", pc_out, 8'h00);
      chk("rst_opcode", opcode, 0);
      reset = 1'b0;
      chk("rst_release_req", imem_req, 1);
      exp_pc = 8'h00;

      for (int i = 0; i < 5; i++) fetch(vecs[i]);

      // PC wrap from 8'hFF.
      pc_load = 1'b1; pc_load_value = 8'hFF;
      step();
      pc_load = 1'b0;
      chk("load_ff_addr", imem_addr, 8'hFF);
      chk("load_ff_valid", instr_valid, 0);
      exp_pc = 8'hFF;
      fetch('{data: 8'h12, wait_cyc: 1, hold_cyc: 0, opc: 2'b00, rd: 3'b010, rs: 3'b010});
      chk("wrap_addr", imem_addr, 8'h00);

      // Redirect in the same cycle as a memory response flushes the data.
      pc_load = 1'b1; pc_load_value = 8'h40; imem_valid = 1'b1; imem_rdata = 8'h5A;
      step();
      pc_load = 1'b0; imem_valid = 1'b0;
      chk("flush_valid", instr_valid, 0);
      chk("flush_addr", imem_addr, 8'h40);
      chk("flush_req", imem_req, 1);
      step();
      chk("flush_valid2", instr_valid, 0);
      exp_pc = 8'h40;

      // Halt, then stray acks/responses are ignored until a redirect.
      fetch('{data: 8'hFF, wait_cyc: 0, hold_cyc: 0, opc: 2'b11, rd: 3'b111, rs: 3'b111});
      for (int k = 0; k < 5; k++) begin
         instr_ack = 1'b1; imem_valid = 1'b1; imem_rdata = 8'h5A;
         step();
         chk("halt_hold", halted, 1);
         chk("halt_hold_req", imem_req, 0);
         chk("halt_hold_valid", instr_valid, 0);
      end
      instr_ack = 1'b0; imem_valid = 1'b0;
      pc_load = 1'b1; pc_load_value = 8'h10;
      step();
      pc_load = 1'b0;
      chk("unhalt_halted", halted, 0);
      chk("unhalt_addr", imem_addr, 8'h10);
      chk("unhalt_req", imem_req, 1);
      exp_pc = 8'h10;

      // Reset while an instruction is issued, ack and a late response held high.
      imem_valid = 1'b1; imem_rdata = 8'h6B; mon_ir = 8'h6B;
      sb.push_back('{addr: 8'h10, opc: 2'b01, rd: 3'b101, rs: 3'b011});
      step();
      imem_valid = 1'b0;
      chk("pre_rst_valid", instr_valid, 1);
      reset = 1'b1; instr_ack = 1'b1; imem_valid = 1'b1;
      step();
      reset = 1'b0; instr_ack = 1'b0; imem_valid = 1'b0;
      chk("midrst_valid", instr_valid, 0);
      chk("midrst_addr", imem_addr, 8'h00);
      chk("midrst_req", imem_req, 1);
      chk("midrst_pc_out", pc_out, 8'h00);
      exp_pc = 8'h00;
      fetch(vecs[0]);

      step();
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
